// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared constants and FSM state type for the SPI register file
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - STAGES-deep flop chain bringing one asynchronous pin into the clk domain
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - mode-0 SPI slave holding the PWM control bytes; SPI_READBACK_EN adds read frames on cipo
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_REGS    = 5,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    logic                  w_sclk_s;
    logic                  w_ncs_s;
    logic                  w_copi_s;
    logic                  r_sclk_d;
    logic                  r_ncs_d;
    spi_state_e            r_state;
    logic [4:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_overflow;
    logic [7:0]            r_regs [NUM_REGS];

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(sclk), .o_q(w_sclk_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .i_d(ncs),  .o_q(w_ncs_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst_n(rst_n), .i_d(copi), .o_q(w_copi_s));

    logic                  w_sclk_rise;
    logic                  w_ncs_fall;
    logic                  w_ncs_rise;
    logic [FRAME_BITS-1:0] w_shift_next;
    logic [6:0]            w_addr;
    logic                  w_commit_wr;

    assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
    assign w_ncs_fall   = ~w_ncs_s & r_ncs_d;
    assign w_ncs_rise   = w_ncs_s & ~r_ncs_d;
    assign w_shift_next = {r_shift[FRAME_BITS-2:0], w_copi_s};
    assign w_addr       = r_shift[14:8];
    assign w_commit_wr  = (r_bit_cnt == 5'(FRAME_BITS)) && !r_overflow && r_shift[15]
                          && (w_addr <= MAX_ADDR);

    // Sync chains reset to 0, so a frame still open when reset releases never shows a falling ncs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_d   <= 1'b0;
            r_ncs_d    <= 1'b0;
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ncs_d  <= w_ncs_s;
            case (r_state)
                IDLE: begin
                    if (w_ncs_fall) begin
                        r_bit_cnt  <= '0;
                        r_shift    <= '0;
                        r_overflow <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_ncs_rise) begin
                        r_state <= COMMIT;
                    end else if (w_sclk_rise && !w_ncs_s) begin
                        if (r_bit_cnt == 5'(FRAME_BITS)) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (w_commit_wr) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_addr == 7'(i)) begin
                                r_regs[i] <= r_shift[7:0];
                            end
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       w_sclk_fall;
    logic       w_rd_valid;
    logic [7:0] w_rd_data;
    logic [7:0] r_tx;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_rd_valid  = !w_shift_next[7] && (w_shift_next[6:0] <= MAX_ADDR);

    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_shift_next[6:0] == 7'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // The falling edge right after the load precedes the sample of bit 7, so shifting starts one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx <= 8'h00;
        end else if (r_state != SHIFT) begin
            r_tx <= 8'h00;
        end else if (w_sclk_rise && !w_ncs_s && (r_bit_cnt == 5'd7)) begin
            r_tx <= w_rd_valid ? w_rd_data : 8'h00;
        end else if (w_sclk_fall && (r_bit_cnt > 5'd8)) begin
            r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    assign cipo = r_tx[7];
`else
    assign cipo = 1'b0;
`endif

    assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = r_regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_peripheral.sv
// tb/tb_spi_peripheral.sv - table vectors, hand sequences and random frames against a register-file model
module tb_spi_peripheral;

`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ncs = 1'b1;
    logic       copi = 1'b0;
    logic       cipo;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic        ext;
        int          n;
        logic [39:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  m [5];
    logic [16:0] cap;
    vec_t        tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_model(input string name);
        for (int i = 0; i < 5; i++) check($sformatf("%s reg%0d", name, i), 32'(dut_reg(i)), 32'(m[i]));
    endtask

    function automatic void model_apply(input logic [16:0] fr, input int n);
        logic [15:0] w = fr[16:1];
        if (n == 16 && w[15] && w[14:8] <= 7'd4) m[int'(w[14:8])] = w[7:0];
    endfunction

    // Controller's view of cipo: the data byte appears on the 9th..16th rising edges of a valid read.
    function automatic logic [16:0] exp_cap(input logic [16:0] fr, input int n);
        logic [15:0] w = fr[16:1];
        logic [16:0] e = '0;
        logic [7:0]  d = 8'h00;
        bit          rd = RB && !w[15] && (w[14:8] <= 7'd4);
        if (rd) d = m[int'(w[14:8])];
        for (int j = 1; j <= n; j++) e = {e[15:0], (rd && j >= 9 && j <= 16) ? d[16-j] : 1'b0};
        return e;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bits(input logic [16:0] fr, input int first, input int n, input int half);
        for (int i = first; i < first + n; i++) begin
            copi = fr[16-i];
            wait_clk(half);
            cap  = {cap[15:0], cipo};
            sclk = 1'b1;
            wait_clk(half);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [16:0] fr, input int n, input int half);
        ncs = 1'b0;
        cap = '0;
        wait_clk(2);
        clock_bits(fr, 0, n, half);
        wait_clk(half);
        ncs = 1'b1;
        wait_clk(10);
    endtask

    initial begin
        int k;
        logic [16:0] fr;
        logic [16:0] e;

        tbl[0] = '{16'h80F0, 1'b0, 16, 40'h00_00_00_00_F0};
        tbl[1] = '{16'h8480, 1'b0, 16, 40'h80_00_00_00_F0};
        tbl[2] = '{16'h84FF, 1'b0, 16, 40'hFF_00_00_00_F0};
        tbl[3] = '{16'h85AA, 1'b0, 16, 40'hFF_00_00_00_F0};
        tbl[4] = '{16'h0255, 1'b0, 16, 40'hFF_00_00_00_F0};
        tbl[5] = '{16'h8155, 1'b0, 15, 40'hFF_00_00_00_F0};
        tbl[6] = '{16'h8155, 1'b1, 17, 40'hFF_00_00_00_F0};
        tbl[7] = '{16'h813C, 1'b0, 16, 40'hFF_00_00_3C_F0};
        tbl[8] = '{16'h8201, 1'b0, 16, 40'hFF_00_01_3C_F0};
        tbl[9] = '{16'hFF00, 1'b0, 16, 40'hFF_00_01_3C_F0};

        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        wait_clk(4);
        check_model("reset");
        check("reset cipo", 32'(cipo), 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        for (int v = 0; v < 10; v++) begin
            send_frame({tbl[v].w, tbl[v].ext}, tbl[v].n, 5);
            model_apply({tbl[v].w, tbl[v].ext}, tbl[v].n);
            for (int i = 0; i < 5; i++)
                check($sformatf("vec%0d reg%0d", v, i), 32'(dut_reg(i)), 32'(tbl[v].exp[8*i +: 8]));
        end

        // Reset in the middle of a frame, released while ncs is still low.
        fr = {16'h8377, 1'b0};
        ncs = 1'b0;
        cap = '0;
        wait_clk(2);
        clock_bits(fr, 0, 9, 5);
        rst_n = 1'b0;
        wait_clk(3);
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        check_model("mid_reset");
        rst_n = 1'b1;
        wait_clk(2);
        clock_bits(fr, 9, 7, 5);
        wait_clk(5);
        ncs = 1'b1;
        wait_clk(10);
        check_model("aborted_frame");
        send_frame(fr, 16, 5);
        model_apply(fr, 16);
        check_model("after_abort");
        check("pwm_hi_77", 32'(en_reg_pwm_15_8), 32'h77);

        // Readback sequence.
        send_frame({16'h825A, 1'b0}, 16, 5);
        model_apply({16'h825A, 1'b0}, 16);
        fr = {16'h0200, 1'b0};
        e = exp_cap(fr, 16);
        send_frame(fr, 16, 5);
        check("readback cipo", 32'(cap), 32'(e));
        check("readback cipo lit", 32'(cap), RB ? 32'h005A : 32'h0);
        check_model("after_read");

        // sclk activity with ncs high must be ignored.
        copi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1; wait_clk(3);
            sclk = 1'b0; wait_clk(3);
        end
        wait_clk(6);
        check_model("sclk_ncs_high");

        for (int r = 0; r < 40; r++) begin
            int n;
            int sel = $urandom_range(0, 5);
            logic [15:0] w = 16'($urandom);
            w[14:8] = 7'($urandom_range(0, 7));
            n  = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            fr = {w, 1'($urandom)};
            e  = exp_cap(fr, n);
            send_frame(fr, n, $urandom_range(3, 6));
            check($sformatf("rand%0d cipo", r), 32'(cap), 32'(e));
            model_apply(fr, n);
            check_model($sformatf("rand%0d", r));
        end

        // Commit latency measured from the ncs pin rising.
        send_frame({16'h8000, 1'b0}, 16, 5);
        ncs = 1'b0;
        wait_clk(2);
        clock_bits({16'h80A5, 1'b0}, 0, 16, 5);
        wait_clk(5);
        ncs = 1'b1;
        k = 0;
        while (en_reg_out_7_0 !== 8'hA5 && k < 12) begin
            wait_clk(1);
            k++;
        end
        check("latency", 32'(k >= 3 && k <= 6), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
